// File: rtl/jk_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jk_reg_bank_pkg
//  Purpose  : Shared mode encodings for the JK register bank.
//             MODE_JK = 00, MODE_D = 01, MODE_T = 10, MODE_SR = 11.
//  Revision : 1.0 - initial release
// ============================================================================
package jk_reg_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

endpackage : jk_reg_bank_pkg
`default_nettype wire

// File: rtl/jk_bit_next.sv
`default_nettype none
// ============================================================================
//  Module   : jk_bit_next
//  Purpose  : Combinational next-state function for one flip-flop bit.
//             Handles the JK, D, T and SR behaviours. It also flags the SR
//             case where S and R are both 1.
//  Ports    : i_q       - current bit state
//             i_j       - J / D / T / S operand
//             i_k       - K / R operand (unused in D and T modes)
//             i_mode    - operating mode
//             o_q_next  - next bit state
//             o_sr_viol - high when mode is SR and S = R = 1
//  Revision : 1.0 - initial release
// ============================================================================
import jk_reg_bank_pkg::*;

module jk_bit_next (
    input  logic  i_q,
    input  logic  i_j,
    input  logic  i_k,
    input  mode_e i_mode,
    output logic  o_q_next,
    output logic  o_sr_viol
);

    always_comb begin
        o_q_next  = i_q;
        o_sr_viol = 1'b0;
        case (i_mode)
            MODE_JK: begin
                case ({i_j, i_k})
                    2'b01:   o_q_next = 1'b0;
                    2'b10:   o_q_next = 1'b1;
                    2'b11:   o_q_next = ~i_q;
                    default: o_q_next = i_q;
                endcase
            end
            MODE_D:  o_q_next = i_j;
            MODE_T:  o_q_next = i_q ^ i_j;
            MODE_SR: begin
                case ({i_j, i_k})
                    2'b01:   o_q_next = 1'b0;
                    2'b10:   o_q_next = 1'b1;
                    // S = R = 1: the bit holds and the violation is reported
                    2'b11:   o_sr_viol = 1'b1;
                    default: o_q_next = i_q;
                endcase
            end
            default: o_q_next = i_q;
        endcase
    end

endmodule : jk_bit_next
`default_nettype wire

// File: rtl/jk_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : jk_reg_bank
//  Purpose  : WIDTH-bit multi-mode flip-flop bank (JK / D / T / SR) with
//             synchronous clear and load, a change flag, a saturating change
//             counter and a sticky SR-violation flag.
//             Priority on each edge is clr, then load, then en.
//  Ports    : clk, reset (async, active-high)
//             j, k, mode, en    - per-bit operands and update control
//             clr, load, d_load - synchronous clear / parallel load
//             err_clr           - clears chg_cnt and sr_err
//             q, qb             - bank state and its complement
//             changed, chg_cnt  - change flag and saturating change count
//             sr_err            - sticky SR S=R=1 flag
//  Revision : 1.0 - initial release
// ============================================================================
import jk_reg_bank_pkg::*;

module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  mode_e            mode,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d_load,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             changed,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sr_err;

    logic [WIDTH-1:0] w_bit_next;
    logic [WIDTH-1:0] w_bit_viol;
    logic [WIDTH-1:0] w_q_next;
    logic             w_changed;
    logic             w_sr_set;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
            jk_bit_next u_bit (
                .i_q       (r_q[gi]),
                .i_j       (j[gi]),
                .i_k       (k[gi]),
                .i_mode    (mode),
                .o_q_next  (w_bit_next[gi]),
                .o_sr_viol (w_bit_viol[gi])
            );
        end
    endgenerate

    always_comb begin
        w_q_next = r_q;
        if (clr)
            w_q_next = '0;
        else if (load)
            w_q_next = d_load;
        else if (en)
            w_q_next = w_bit_next;
    end

    // A violation only counts when the per-bit logic actually drives q.
    assign w_sr_set  = en & ~clr & ~load & (mode == MODE_SR) & (|w_bit_viol);
    assign w_changed = (w_q_next != r_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q       <= RESET_VAL;
            r_changed <= 1'b0;
            r_cnt     <= '0;
            r_sr_err  <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_changed;

            // err_clr restarts the count, so a change on the same edge gives 1
            if (err_clr)
                r_cnt <= w_changed ? c_CNT_ONE : '0;
            else if (w_changed && (r_cnt != c_CNT_MAX))
                r_cnt <= r_cnt + c_CNT_ONE;

            // A new violation beats err_clr on the same edge
            if (w_sr_set)
                r_sr_err <= 1'b1;
            else if (err_clr)
                r_sr_err <= 1'b0;
        end
    end

    assign q       = r_q;
    assign qb      = ~r_q;
    assign changed = r_changed;
    assign chg_cnt = r_cnt;
    assign sr_err  = r_sr_err;

endmodule : jk_reg_bank
`default_nettype wire

// File: tb/tb_jk_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_reg_bank
//  Purpose  : Directed self-checking bench for jk_reg_bank
//             (WIDTH=8, CNT_W=4, RESET_VAL=8'h00).
//  Revision : 1.0 - initial release
// ============================================================================
import jk_reg_bank_pkg::*;

module tb_jk_reg_bank;

    logic       clk;
    logic       reset;
    logic [7:0] j;
    logic [7:0] k;
    mode_e      mode;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] d_load;
    logic       err_clr;
    logic [7:0] q;
    logic [7:0] qb;
    logic       changed;
    logic [3:0] chg_cnt;
    logic       sr_err;

    int n_total = 0;
    int n_pass  = 0;

    jk_reg_bank #(
        .WIDTH     (8),
        .CNT_W     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .j       (j),
        .k       (k),
        .mode    (mode),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .d_load  (d_load),
        .err_clr (err_clr),
        .q       (q),
        .qb      (qb),
        .changed (changed),
        .chg_cnt (chg_cnt),
        .sr_err  (sr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        j       = 8'h00;
        k       = 8'h00;
        mode    = MODE_JK;
        en      = 1'b0;
        clr     = 1'b0;
        load    = 1'b0;
        d_load  = 8'h00;
        err_clr = 1'b0;
        #2;
        check("rst_q",       q,       8'h00);
        check("rst_qb",      qb,      8'hFF);
        check("rst_changed", changed, 1'b0);
        check("rst_cnt",     chg_cnt, 4'd0);
        check("rst_sr_err",  sr_err,  1'b0);
        step();
        @(negedge clk);
        reset = 1'b0;

        // JK set/clear, then toggle
        mode = MODE_JK; en = 1'b1; j = 8'hF0; k = 8'h0F;
        step();
        check("jk1_q",       q,       8'hF0);
        check("jk1_qb",      qb,      8'h0F);
        check("jk1_changed", changed, 1'b1);
        check("jk1_cnt",     chg_cnt, 4'd1);
        j = 8'hFF; k = 8'hFF;
        step();
        check("jk2_q",   q,       8'h0F);
        check("jk2_cnt", chg_cnt, 4'd2);

        // clr counts as a change and does not reset the counter
        clr = 1'b1;
        step();
        check("clr_q",   q,       8'h00);
        check("clr_cnt", chg_cnt, 4'd3);
        clr = 1'b0;

        // SR violation holds q and sets sticky flag
        mode = MODE_SR; j = 8'h01; k = 8'h01;
        step();
        check("sr_q",       q,       8'h00);
        check("sr_err",     sr_err,  1'b1);
        check("sr_changed", changed, 1'b0);
        check("sr_cnt",     chg_cnt, 4'd3);
        err_clr = 1'b1; j = 8'h00; k = 8'h00;
        step();
        check("errclr_sr_err", sr_err,  1'b0);
        check("errclr_cnt",    chg_cnt, 4'd0);
        err_clr = 1'b0;

        // SR set / clear
        j = 8'h81; k = 8'h00;
        step();
        check("sr_set_q", q, 8'h81);
        j = 8'h00; k = 8'h01;
        step();
        check("sr_clrbit_q", q,       8'h80);
        check("sr_clr_cnt",  chg_cnt, 4'd2);

        // Load 55, then clr beats load, then load AA
        load = 1'b1; d_load = 8'h55;
        step();
        check("load55_q", q, 8'h55);
        clr = 1'b1; d_load = 8'hAA; mode = MODE_JK; j = 8'hFF; k = 8'h00;
        step();
        check("clr_wins_q", q, 8'h00);
        clr = 1'b0;
        step();
        check("loadAA_q",   q,       8'hAA);
        check("loadAA_cnt", chg_cnt, 4'd5);
        // Load of the same value is not a change
        step();
        check("load_same_changed", changed, 1'b0);
        check("load_same_cnt",     chg_cnt, 4'd5);
        load = 1'b0;

        // Zero the counter, then saturate with T mode toggles
        err_clr = 1'b1; en = 1'b0;
        step();
        check("cnt_zero", chg_cnt, 4'd0);
        err_clr = 1'b0;
        mode = MODE_T; j = 8'h01; k = 8'hFF; en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) check("t_cnt15", chg_cnt, 4'd15);
        end
        check("t_sat_cnt", chg_cnt, 4'd15);
        check("t_sat_q",   q,       8'hAA);
        err_clr = 1'b1;
        step();
        check("t_errclr_cnt", chg_cnt, 4'd1);
        check("t_errclr_q",   q,       8'hAB);

        // err_clr coinciding with a new violation: set wins
        mode = MODE_SR; j = 8'h10; k = 8'h10;
        step();
        check("setwins_sr_err", sr_err, 1'b1);
        j = 8'h00; k = 8'h00;
        step();
        check("sr_err_cleared", sr_err, 1'b0);
        err_clr = 1'b0;

        // Violation while disabled does not set the flag
        en = 1'b0; j = 8'hFF; k = 8'hFF;
        step();
        check("sr_dis_err", sr_err, 1'b0);
        // Violation masked by load does not set the flag
        en = 1'b1; load = 1'b1; d_load = 8'hAB;
        step();
        check("sr_load_err", sr_err, 1'b0);
        load = 1'b0;

        // Reset mid-operation
        mode = MODE_D; j = 8'h3C; en = 1'b1;
        step();
        check("d_q", q, 8'h3C);
        j = 8'hFF;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_q",   q,       8'h00);
        check("async_rst_qb",  qb,      8'hFF);
        check("async_rst_cnt", chg_cnt, 4'd0);
        step();
        step();
        check("rst_hold_q", q, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Disabled D mode holds
        en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("en0_q",       q,       8'h00);
        check("en0_changed", changed, 1'b0);
        check("en0_cnt",     chg_cnt, 4'd0);

        // First enabled edge after reset updates
        en = 1'b1;
        step();
        check("post_rst_q",   q,       8'hFF);
        check("post_rst_cnt", chg_cnt, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_jk_reg_bank
`default_nettype wire

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of flip-flop bits in the bank.
REQ-002 Parameter CNT_W, default 8, width of the change counter.
REQ-003 Parameter RESET_VAL, default all-zero WIDTH bits, value loaded into q on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 j  input  WIDTH  per-bit J / D / T / S operand, depending on mode.
REQ-007 k  input  WIDTH  per-bit K / R operand; ignored in D and T modes.
REQ-008 mode  input  2  00=JK, 01=D, 10=T, 11=SR.
REQ-009 en  input  1  update enable; en=0 holds q.
REQ-010 clr  input  1  synchronous clear of q to all-zero.
REQ-011 load  input  1  synchronous parallel load of d_load into q.
REQ-012 d_load  input  WIDTH  parallel load data.
REQ-013 err_clr  input  1  synchronous clear of sr_err and chg_cnt.
REQ-014 q  output  WIDTH  registered bank state.
REQ-015 qb  output  WIDTH  bitwise complement of q, always equal to ~q.
REQ-016 changed  output  1  registered flag, high for the cycle after any edge that altered q.
REQ-017 chg_cnt  output  CNT_W  saturating count of edges that altered q.
REQ-018 sr_err  output  1  sticky flag for SR mode with S=R=1 on any enabled bit.

Function
REQ-019 Priority per edge SHALL be clr > load > en; en=0 with clr=0 and load=0 holds q.
REQ-020 JK mode, per bit: 00 hold, 01 (j=0,k=1) clear, 10 (j=1,k=0) set, 11 toggle.
REQ-021 D mode: q <= j; k is ignored.
REQ-022 T mode: bits with j=1 toggle, bits with j=0 hold; k is ignored.
REQ-023 SR mode: S=1,R=0 sets; S=0,R=1 clears; S=R=0 holds; S=R=1 holds the bit and sets sr_err.
REQ-024 sr_err sets only when en=1, clr=0, load=0 and mode=11; it stays set until err_clr or reset.
REQ-025 Update latency SHALL be one edge: q reflects the inputs sampled at the preceding rising edge.
REQ-026 changed <= (q_next != q) at every edge; clr, load and mode updates all count.
REQ-027 chg_cnt increments by 1 on each edge where q_next != q and saturates at 2^CNT_W-1, with no wrap.
REQ-028 err_clr zeroes chg_cnt and clears sr_err on that edge.
REQ-029 If err_clr coincides with a new SR violation, sr_err SHALL end set (set wins).
REQ-030 If err_clr coincides with a change, chg_cnt SHALL end at 1.
REQ-031 clr does not affect chg_cnt or sr_err.
REQ-032 A clr or load that leaves q unchanged SHALL not pulse changed or increment chg_cnt.

Reset
REQ-033 reset=1 SHALL immediately force q=RESET_VAL, qb=~RESET_VAL, changed=0, chg_cnt=0 and sr_err=0, independent of clk.
REQ-034 While reset=1, no input is sampled.
REQ-035 The first update occurs on the first rising edge after reset deasserts.
REQ-036 A reset asserted mid-operation discards any pending update.

Structure
REQ-037 A shared package SHALL hold the mode encodings (JK, D, T, SR) and the 2-bit mode type.
REQ-038 One combinational sub-module, jk_bit_next, SHALL compute the per-bit next state and the per-bit SR-violation flag from q, j, k and mode.
REQ-039 jk_bit_next SHALL be instantiated WIDTH times.
REQ-040 Priority, counter and flag logic SHALL live in jk_reg_bank.

Verification (WIDTH=8, CNT_W=4, RESET_VAL=8'h00)
REQ-041 Reset, then mode=JK, en=1, j=8'hF0, k=8'h0F, one edge -> q=8'hF0, qb=8'h0F, changed=1, chg_cnt=1; then j=k=8'hFF, one edge -> q=8'h0F, chg_cnt=2.
REQ-042 mode=SR, en=1, j=8'h01, k=8'h01 with q=8'h00 -> q holds 8'h00, sr_err=1, changed=0; then err_clr=1 with j=k=8'h00 -> sr_err=0, chg_cnt=0.
REQ-043 clr=1, load=1, d_load=8'hAA, en=1 with q=8'h55 -> q=8'h00 (clr wins); next edge with clr=0, load=1 -> q=8'hAA.
REQ-044 mode=T, j=8'h01, en=1 for 20 edges -> chg_cnt saturates at 15; err_clr on the 21st edge -> chg_cnt=1.
REQ-045 Assert reset between clock edges with q=8'h3C -> q=8'h00 and chg_cnt=0 before the next edge; hold reset across 2 edges with en=1, j=8'hFF -> q stays 8'h00.
REQ-046 en=0, mode=D, j=8'hFF for 3 edges -> q unchanged, changed=0, chg_cnt unchanged.
